// File: rtl/sequencer_scheduler.sv
// Round-robin front end for a shared serializing sequencer: picks one requester,
// loads its vector into the sequencer, then drives the TRIGGER waveform for every word.
module sequencer_scheduler #(
    parameter int NUM_SOURCES = 2,
    parameter int NUM_INPUTS  = 4,
    parameter int WIDTH       = 8,
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 3
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [NUM_SOURCES*NUM_INPUTS*WIDTH-1:0]   REQ_VALUES,
    input  logic [NUM_SOURCES-1:0]                    REQ_VALID,
    output logic [NUM_SOURCES-1:0]                    REQ_READY,
    output logic [NUM_INPUTS*WIDTH-1:0]               SEQ_VALUES_OUT,
    output logic                                      SEQ_VALID_OUT,
    output logic                                      SEQ_TRIGGER,
    output logic [((NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1)-1:0] GRANT_ID,
    output logic                                      BUSY,
    output logic                                      DONE
);
    localparam int GW   = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1;
    localparam int VW   = NUM_INPUTS * WIDTH;
    localparam int PMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(NUM_INPUTS);

    typedef enum logic [2:0] {IDLE, GRANT, PUSH, HIGH, LOW, DONE_ST} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d, last_q, last_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [VW-1:0]          vals_q, vals_d;
    logic [NUM_SOURCES-1:0] ready_q, ready_d;
    logic                   sval_q, sval_d, trig_q, trig_d, busy_q, busy_d, done_q, done_d;
    logic                   found;
    logic [GW-1:0]          win;
    int                     idx;

    // Search starts just past the previous winner so every source gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx = (int'(last_q) + k) % NUM_SOURCES;
            if (!found && REQ_VALID[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        vals_d  = vals_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = win;
                last_d  = win;
                state_d = GRANT;
            end
            GRANT: begin
                vals_d  = REQ_VALUES[int'(grant_q)*VW +: VW];
                state_d = PUSH;
            end
            PUSH: begin
                beat_d  = '0;
                phase_d = PW'(HIGH_CYCLES - 1);
                state_d = HIGH;
            end
            HIGH: if (phase_q == '0) begin
                phase_d = PW'(LOW_CYCLES - 1);
                state_d = LOW;
            end else begin
                phase_d = phase_q - 1'b1;
            end
            LOW: if (phase_q == '0) begin
                if (beat_q < BW'(NUM_INPUTS - 1)) begin
                    beat_d  = beat_q + 1'b1;
                    phase_d = PW'(HIGH_CYCLES - 1);
                    state_d = HIGH;
                end else begin
                    state_d = DONE_ST;
                end
            end else begin
                phase_d = phase_q - 1'b1;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ready_d = '0;
        if (state_d == GRANT) ready_d[grant_d] = 1'b1;
        sval_d = (state_d == PUSH);
        trig_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE_ST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_SOURCES - 1);
            phase_q <= '0;
            beat_q  <= '0;
            vals_q  <= '0;
            ready_q <= '0;
            sval_q  <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            beat_q  <= beat_d;
            vals_q  <= vals_d;
            ready_q <= ready_d;
            sval_q  <= sval_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign REQ_READY      = ready_q;
    assign SEQ_VALUES_OUT = vals_q;
    assign SEQ_VALID_OUT  = sval_q;
    assign SEQ_TRIGGER    = trig_q;
    assign GRANT_ID       = grant_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
endmodule

// File: tb/tb_sequencer_scheduler.sv
// Scoreboard bench: default-parameter scheduler plus a 3-source/2-word/5-high/4-low instance.
module tb_sequencer_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_values;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] seq_values;
    logic        seq_valid, seq_trig, busy, done;
    logic [0:0]  gid;

    logic [47:0] req_values2;
    logic [2:0]  req_valid2, ready2;
    logic [15:0] vals2;
    logic        sv2, trig2, busy2, done2;
    logic [1:0]  gid2;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          src;
        logic [31:0] vals;
        int          req_cyc;
        int          wait_max;
    } item_t;
    item_t sbq[$];
    int    sb2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequencer_scheduler dut (
        .CLK(clk), .RST(rst), .REQ_VALUES(req_values), .REQ_VALID(req_valid),
        .REQ_READY(req_ready), .SEQ_VALUES_OUT(seq_values), .SEQ_VALID_OUT(seq_valid),
        .SEQ_TRIGGER(seq_trig), .GRANT_ID(gid), .BUSY(busy), .DONE(done)
    );

    sequencer_scheduler #(.NUM_SOURCES(3), .NUM_INPUTS(2), .WIDTH(8),
                          .HIGH_CYCLES(5), .LOW_CYCLES(4)) dut2 (
        .CLK(clk), .RST(rst), .REQ_VALUES(req_values2), .REQ_VALID(req_valid2),
        .REQ_READY(ready2), .SEQ_VALUES_OUT(vals2), .SEQ_VALID_OUT(sv2),
        .SEQ_TRIGGER(trig2), .GRANT_ID(gid2), .BUSY(busy2), .DONE(done2)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_item(input int src, input logic [31:0] vals, input int rc, input int wm);
        item_t it;
        it.src = src; it.vals = vals; it.req_cyc = rc; it.wait_max = wm;
        sbq.push_back(it);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", req_ready, 0);
        chk("rst_sval", seq_valid, 0);
        chk("rst_trig", seq_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gid", gid, 0);
        chk("rst_vals", seq_values, 0);
    endtask

    // Pops one expected transaction and follows it cycle by cycle until IDLE.
    task automatic run_txn(input bit drop);
        item_t it;
        int    w, g;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        it = sbq.pop_front();
        w = 0;
        while (req_ready == 0 && w < it.wait_max) begin
            tick();
            w++;
        end
        chk("grant_seen", (req_ready != 0), 1);
        if (req_ready == 0) return;
        chk("ready", req_ready, 64'(1) << it.src);
        chk("gid", gid, it.src);
        chk("busy_grant", busy, 1);
        g = cyc;
        if (it.req_cyc >= 0) chk("grant_lat", g - it.req_cyc, 1);
        tick();
        if (drop) begin
            req_valid[it.src] = 1'b0;
            req_values[it.src*32 +: 32] = ~it.vals;
        end
        chk("push_sval", seq_valid, 1);
        chk("push_vals", seq_values, it.vals);
        chk("push_trig", seq_trig, 0);
        for (int b = 0; b < 4; b++) begin
            for (int h = 0; h < 3; h++) begin
                tick();
                chk("trig_hi", seq_trig, 1);
                chk("ready_busy", req_ready, 0);
            end
            for (int l = 0; l < 3; l++) begin
                tick();
                chk("trig_lo", seq_trig, 0);
                chk("done_early", done, 0);
            end
        end
        tick();
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("done_lat", cyc - g, 26);
        chk("vals_hold", seq_values, it.vals);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, g, t0, e, ndone;
        logic [15:0] v2;
        rst = 1'b1;
        req_valid = '0; req_values = '0;
        req_valid2 = '0; req_values2 = '0;
        repeat (2) tick();
        chk_reset_outs();
        rst = 1'b0;
        tick();

        // Single request from source 0.
        req_values[31:0] = 32'h44332211;
        req_valid[0] = 1'b1;
        push_item(0, 32'h44332211, cyc, 1);
        run_txn(1);

        // Simultaneous requests right after reset: 0 first, then 1 right after IDLE.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_values = {32'hB4B3B2B1, 32'hA4A3A2A1};
        req_valid = 2'b11;
        push_item(0, 32'hA4A3A2A1, cyc, 1);
        push_item(1, 32'hB4B3B2B1, -1, 1);
        run_txn(1);
        run_txn(1);

        // Sustained requests alternate.
        req_values = {32'h0D0C0B0A, 32'h04030201};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++)
            push_item(i % 2, (i % 2) ? 32'h0D0C0B0A : 32'h04030201, -1, 1);
        for (int i = 0; i < 6; i++) run_txn(0);
        req_valid = 2'b00;

        // Reset during the second HIGH phase.
        tick();
        req_values[31:0] = 32'h55667788;
        req_valid[0] = 1'b1;
        tick();
        chk("mr_ready", req_ready, 1);
        tick();
        req_valid[0] = 1'b0;
        repeat (7) tick();
        chk("mr_trig_before", seq_trig, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outs();
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("mr_no_done", ndone, 0);
        req_values[63:32] = 32'h99AABBCC;
        req_valid[1] = 1'b1;
        push_item(1, 32'h99AABBCC, cyc, 1);
        run_txn(1);

        // Late request from source 1 during source 0's third beat.
        req_values[31:0] = 32'h0F1E2D3C;
        req_valid[0] = 1'b1;
        push_item(0, 32'h0F1E2D3C, cyc, 1);
        push_item(1, 32'h5A6B7C8D, -1, 1);
        fork
            run_txn(1);
            begin
                repeat (16) tick();
                req_values[63:32] = 32'h5A6B7C8D;
                req_valid[1] = 1'b1;
            end
        join
        run_txn(1);

        // Parameter sweep instance: 3 sources, 2 words, 5 high / 4 low.
        req_values2 = {16'hC2C1, 16'hB2B1, 16'hA2A1};
        req_valid2 = 3'b111;
        t0 = cyc;
        sb2.push_back(0); sb2.push_back(1); sb2.push_back(2);
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (ready2 == 0 && w < 50) begin tick(); w++; end
            chk("sw_grant_seen", (ready2 != 0), 1);
            e = sb2.pop_front();
            chk("sw_ready", ready2, 64'(1) << e);
            chk("sw_gid", gid2, e);
            g = cyc;
            if (i == 0) chk("sw_grant_lat", g - t0, 1);
            tick();
            req_valid2[e] = 1'b0;
            w = 0;
            while (!done2 && w < 50) begin tick(); w++; end
            chk("sw_done_lat", cyc - g, 20);
            if (i == 0) chk("sw_req_to_done", cyc - t0, 21);
            v2 = (e == 0) ? 16'hA2A1 : (e == 1) ? 16'hB2B1 : 16'hC2C1;
            chk("sw_vals", vals2, v2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
